// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter packing up to NUM_WB of NUM_IN FU writebacks per cycle
package wb_pkg;
  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [3:0]  irob_idx;
    logic        use_imm;
    logic        rd_wen;
    logic [6:0]  iprd_idx;
    logic [31:0] result;
  } comwbInfo_t;
endpackage

module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int NUM_WB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] i_fu_finished,
  input  comwbInfo_t        i_comwbInfo [NUM_IN],
  input  logic              i_commit_stall,
  output logic [NUM_IN-1:0] o_wb_stall,
  output logic [NUM_WB-1:0] o_wb_vld,
  output comwbInfo_t        o_wb_info [NUM_WB],
  output logic [NUM_WB-1:0] o_rf_wen
);
  localparam int RW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  logic [RW-1:0]     rr_ptr, rr_nxt;
  logic [NUM_IN-1:0] grant;
  logic [NUM_WB-1:0] fill;
  logic [RW-1:0]     sel [NUM_WB];
  logic              collide;
  // scan from rr_ptr; the n-th valid input found lands in slot n
  always_comb begin
    int cnt;
    logic [RW-1:0] idx;
    grant = '0;
    fill = '0;
    rr_nxt = rr_ptr;
    cnt = 0;
    idx = '0;
    for (int j = 0; j < NUM_WB; j++) sel[j] = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = RW'((int'(rr_ptr) + i) % NUM_IN);
      if (rst && !i_commit_stall && i_fu_finished[idx] && cnt < NUM_WB) begin
        grant[idx] = 1'b1;
        for (int j = 0; j < NUM_WB; j++)
          if (j == cnt) begin
            sel[j] = idx;
            fill[j] = 1'b1;
          end
        rr_nxt = RW'((int'(idx) + 1) % NUM_IN);
        cnt++;
      end
    end
  end
  assign o_wb_stall = rst ? (i_fu_finished & ~grant) : '0;
  always_comb begin
    for (int j = 0; j < NUM_WB; j++) o_rf_wen[j] = o_wb_vld[j] & o_wb_info[j].rd_wen;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_wb_vld <= '0;
      rr_ptr <= '0;
    end else if (!i_commit_stall) begin
      o_wb_vld <= fill;
      rr_ptr <= rr_nxt;
      for (int j = 0; j < NUM_WB; j++)
        if (fill[j]) o_wb_info[j] <= i_comwbInfo[sel[j]];
    end
  end
  // two writers to the same physical register in one cycle is an upstream bug
  always_comb begin
    collide = 1'b0;
    for (int a = 0; a < NUM_WB; a++)
      for (int b = a + 1; b < NUM_WB; b++)
        if (fill[a] && fill[b] && i_comwbInfo[sel[a]].rd_wen && i_comwbInfo[sel[b]].rd_wen &&
            i_comwbInfo[sel[a]].iprd_idx == i_comwbInfo[sel[b]].iprd_idx)
          collide = 1'b1;
  end
  a_no_collide: assert property (@(posedge clk) !collide);
endmodule
